// File: rtl/serial_add_seq.sv
// Bit-serial operand sequencer and result collector for a registered one-bit adder.
// Optional initial-carry input port enabled by defining SERIAL_ADD_CIN_EN.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_CIN_EN
  input  logic             carry_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             add_a,
  output logic             add_b,
  output logic             add_cin,
  input  logic             add_sum,
  input  logic             add_cout
);

  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_issue_idx;
  logic [IW-1:0]    r_cap_idx;
  logic             r_first;
  logic             r_cin_init;
  logic             r_busy;
  logic             r_done;
  logic             r_carry_out;
  logic             r_add_a;
  logic             r_add_b;
  logic             w_cin_now;

`ifdef SERIAL_ADD_CIN_EN
  assign w_cin_now = carry_in;
`else
  assign w_cin_now = 1'b0;
`endif

  // The carry loop closes through the adder's registered cout once bit 0 has been sampled.
  assign add_cin   = r_first ? r_cin_init : add_cout;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_result    <= '0;
      r_issue_idx <= '0;
      r_cap_idx   <= '0;
      r_first     <= 1'b1;
      r_cin_init  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_carry_out <= 1'b0;
      r_add_a     <= 1'b0;
      r_add_b     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_sh_a      <= op_a >> 1;
            r_sh_b      <= op_b >> 1;
            r_add_a     <= op_a[0];
            r_add_b     <= op_b[0];
            r_issue_idx <= '0;
            r_cap_idx   <= '0;
            r_first     <= 1'b1;
            r_cin_init  <= w_cin_now;
            r_busy      <= 1'b1;
            r_state     <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_first <= 1'b0;
          if (r_issue_idx != LAST) begin
            r_issue_idx <= r_issue_idx + 1'b1;
            r_add_a     <= r_sh_a[0];
            r_add_b     <= r_sh_b[0];
            r_sh_a      <= r_sh_a >> 1;
            r_sh_b      <= r_sh_b >> 1;
          end else begin
            r_add_a <= 1'b0;
            r_add_b <= 1'b0;
          end
          // Capture lags issue by one edge because the adder output is registered.
          if (!r_first) begin
            for (int k = 0; k < WIDTH; k++) begin
              if (r_cap_idx == IW'(k)) r_result[k] <= add_sum;
            end
            if (r_cap_idx == LAST) begin
              r_carry_out <= add_cout;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_cap_idx <= r_cap_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: an 8-bit and a 2-bit instance, each with a
// behavioural registered one-bit adder; expected sums are queued at start and popped at done.
module tb_serial_add_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

`ifdef SERIAL_ADD_CIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  // 8-bit instance signals
  logic       start8;
  logic [7:0] opA8, opB8;
  logic       busy8, done8, carryOut8, addA8, addB8, addCin8;
  logic [7:0] result8;
  logic       sum8 = 1'b0, cout8 = 1'b0;
  logic [8:0] expQ8[$];
`ifdef SERIAL_ADD_CIN_EN
  logic       cin8;
`endif

  // 2-bit instance signals
  logic       start2;
  logic [1:0] opA2, opB2;
  logic       busy2, done2, carryOut2, addA2, addB2, addCin2;
  logic [1:0] result2;
  logic       sum2 = 1'b0, cout2 = 1'b0;
  logic [2:0] expQ2[$];
`ifdef SERIAL_ADD_CIN_EN
  logic       cin2;
`endif

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(opA8), .op_b(opB8),
`ifdef SERIAL_ADD_CIN_EN
    .carry_in(cin8),
`endif
    .busy(busy8), .done(done8), .result(result8), .carry_out(carryOut8),
    .add_a(addA8), .add_b(addB8), .add_cin(addCin8), .add_sum(sum8), .add_cout(cout8)
  );

  serial_add_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op_a(opA2), .op_b(opB2),
`ifdef SERIAL_ADD_CIN_EN
    .carry_in(cin2),
`endif
    .busy(busy2), .done(done2), .result(result2), .carry_out(carryOut2),
    .add_a(addA2), .add_b(addB2), .add_cin(addCin2), .add_sum(sum2), .add_cout(cout2)
  );

  // Behavioural registered full adders: sum and cout reflect inputs from the previous edge
  always @(posedge clk) begin
    sum8  <= addA8 ^ addB8 ^ addCin8;
    cout8 <= (addA8 & addB8) | (addA8 & addCin8) | (addB8 & addCin8);
    sum2  <= addA2 ^ addB2 ^ addCin2;
    cout2 <= (addA2 & addB2) | (addA2 & addCin2) | (addB2 & addCin2);
  end

  // Drive a one-cycle start on the 8-bit instance; returns at the negedge after the start edge
  task automatic startOp8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push);
    @(negedge clk);
    opA8 = a; opB8 = b; start8 = 1'b1;
`ifdef SERIAL_ADD_CIN_EN
    cin8 = c;
`endif
    if (push) expQ8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c & CIN_EN});
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Wait (bounded) for done8; lat = clocks from start edge, -1 on timeout
  task automatic waitDone8(output int lat, output bit busyOk, output logic [7:0] cinTrace);
    lat = -1; busyOk = 1'b1; cinTrace = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done8 === 1'b1) begin
        lat = cyc;
        return;
      end
      if (busy8 !== 1'b1) busyOk = 1'b0;
      if (cyc < 8) cinTrace[cyc] = addCin8;
      @(negedge clk);
    end
  endtask

  task automatic startOp2(input logic [1:0] a, input logic [1:0] b, input logic c);
    @(negedge clk);
    opA2 = a; opB2 = b; start2 = 1'b1;
`ifdef SERIAL_ADD_CIN_EN
    cin2 = c;
`endif
    expQ2.push_back({1'b0, a} + {1'b0, b} + {2'd0, c & CIN_EN});
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic waitDone2(output int lat);
    lat = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done2 === 1'b1) begin
        lat = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [13:0] got;
    rst_n = 1'b0;
    #2;
    got = {busy8, done8, result8, carryOut8, addA8, addB8, addCin8};
    checks++;
    if (got !== 14'd0) begin
      failures++;
      $display("[TB] FAIL reset_values: got %h required %h", got, 14'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy8, done8, busy2, done2} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got %b required 0000", {busy8, done8, busy2, done2});
    end
  endtask

  task automatic test_basic();
    int lat; bit busyOk; logic [7:0] tr; logic [8:0] exp;
    startOp8(8'h5A, 8'h3C, 1'b0, 1'b1);
    waitDone8(lat, busyOk, tr);
    exp = expQ8.pop_front();
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d required 9", lat);
    end
    checks++;
    if (!busyOk || busy8 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_busy: busyDuringRun=%0d busyAtDone=%b required 1/0", busyOk, busy8);
    end
    checks++;
    if ({carryOut8, result8} !== exp || exp !== 9'h096) begin
      failures++;
      $display("[TB] FAIL basic_result: got %h required %h", {carryOut8, result8}, exp);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || {carryOut8, result8} !== exp) begin
      failures++;
      $display("[TB] FAIL basic_done_pulse_hold: done=%b result=%h required 0/%h", done8, {carryOut8, result8}, exp);
    end
  endtask

  task automatic test_carry_chain();
    int lat; bit busyOk; logic [7:0] tr; logic [8:0] exp;
    startOp8(8'hFF, 8'h01, 1'b0, 1'b1);
    waitDone8(lat, busyOk, tr);
    exp = expQ8.pop_front();
    checks++;
    if ({carryOut8, result8} !== exp || lat !== 9) begin
      failures++;
      $display("[TB] FAIL carry_result: got %h lat %0d required %h lat 9", {carryOut8, result8}, lat, exp);
    end
    checks++;
    if (tr !== 8'hFE) begin
      failures++;
      $display("[TB] FAIL carry_cin_trace: got %b required %b", tr, 8'hFE);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit busyOk; logic [7:0] tr; logic [8:0] exp;
    @(negedge clk);
    opA8 = 8'h0F; opB8 = 8'h01; start8 = 1'b1;
`ifdef SERIAL_ADD_CIN_EN
    cin8 = 1'b0;
`endif
    expQ8.push_back(9'h010);
    @(posedge clk);
    @(negedge clk);
    opA8 = 8'h80; opB8 = 8'h80;
    expQ8.push_back(9'h100);
    waitDone8(lat, busyOk, tr);
    exp = expQ8.pop_front();
    checks++;
    if ({carryOut8, result8} !== exp || lat !== 9) begin
      failures++;
      $display("[TB] FAIL b2b_first: got %h lat %0d required %h lat 9", {carryOut8, result8}, lat, exp);
    end
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_restart: busy got %b required 1", busy8);
    end
    waitDone8(lat, busyOk, tr);
    exp = expQ8.pop_front();
    checks++;
    if ({carryOut8, result8} !== exp || lat !== 9) begin
      failures++;
      $display("[TB] FAIL b2b_second: got %h lat %0d required %h lat 9", {carryOut8, result8}, lat, exp);
    end
  endtask

  task automatic test_reset_abort();
    int lat; bit busyOk; logic [7:0] tr; logic [8:0] exp; logic [13:0] got; bit sawDone;
    startOp8(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {busy8, done8, result8, carryOut8, addA8, addB8, addCin8};
    checks++;
    if (got !== 14'd0) begin
      failures++;
      $display("[TB] FAIL abort_reset_values: got %h required %h", got, 14'd0);
    end
    #3 rst_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin
      failures++;
      $display("[TB] FAIL abort_no_done: activity seen after abort, required none");
    end
    startOp8(8'h01, 8'h02, 1'b0, 1'b1);
    waitDone8(lat, busyOk, tr);
    exp = expQ8.pop_front();
    checks++;
    if ({carryOut8, result8} !== exp || lat !== 9) begin
      failures++;
      $display("[TB] FAIL abort_recover: got %h lat %0d required %h lat 9", {carryOut8, result8}, lat, exp);
    end
  endtask

`ifdef SERIAL_ADD_CIN_EN
  task automatic test_carry_in();
    int lat; bit busyOk; logic [7:0] tr; logic [8:0] exp;
    startOp8(8'hFF, 8'h00, 1'b1, 1'b1);
    cin8 = 1'b0;
    waitDone8(lat, busyOk, tr);
    exp = expQ8.pop_front();
    checks++;
    if ({carryOut8, result8} !== exp || lat !== 9) begin
      failures++;
      $display("[TB] FAIL carry_in_result: got %h lat %0d required %h lat 9", {carryOut8, result8}, lat, exp);
    end
  endtask
`endif

  task automatic test_width2();
    int lat; logic [2:0] exp;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c <= int'(CIN_EN); c++) begin
          startOp2(2'(a), 2'(b), 1'(c));
          waitDone2(lat);
          exp = expQ2.pop_front();
          checks++;
          if ({carryOut2, result2} !== exp || lat !== 3) begin
            failures++;
            $display("[TB] FAIL w2_sum a=%0d b=%0d c=%0d: got %h lat %0d required %h lat 3",
                     a, b, c, {carryOut2, result2}, lat, exp);
          end
        end
      end
    end
  endtask

  initial begin
    start8 = 1'b0; opA8 = '0; opB8 = '0;
    start2 = 1'b0; opA2 = '0; opB2 = '0;
`ifdef SERIAL_ADD_CIN_EN
    cin8 = 1'b0; cin2 = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_ADD_CIN_EN
    test_carry_in();
`endif
    test_width2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
